fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller and its queue.
package fetch_pkg;

    localparam int          QDEPTH       = 4;
    localparam int          PTR_W        = 2;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Four-entry instruction FIFO with two write ports and two read ports.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_flush,
    input  logic [1:0]     i_push,
    input  logic [1:0]     i_pop,
    input  q_entry_t       i_wdata0,
    input  q_entry_t       i_wdata1,
    output q_entry_t       o_rdata0,
    output q_entry_t       o_rdata1,
    output logic [2:0]     o_count
);

    q_entry_t           r_mem [0:QDEPTH-1];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [2:0]         r_count;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (i_push != 2'd0) begin
                r_mem[r_tail] <= i_wdata0;
            end
            if (i_push == 2'd2) begin
                r_mem[r_tail + 2'd1] <= i_wdata1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            r_head  <= r_head + i_pop;
            r_tail  <= r_tail + i_push;
            r_count <= r_count - {1'b0, i_pop} + {1'b0, i_push};
        end
    end

    assign o_rdata0 = r_mem[r_head];
    assign o_rdata1 = r_mem[r_head + 2'd1];
    assign o_count  = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, dual-word fetch, redirect handling and a
// two-wide decode interface fed from a four-entry instruction queue.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC_DEF,
    parameter int          QDEPTH   = fetch_pkg::QDEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic [31:0] imem_rd2,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [1:0]  dec_valid,
    output logic [31:0] dec_instr0,
    output logic [31:0] dec_pc0,
    output logic [31:0] dec_instr1,
    output logic [31:0] dec_pc1,
    input  logic [1:0]  dec_take,
    output logic [2:0]  q_count
);

    import fetch_pkg::*;

    localparam logic [2:0] DEPTH3 = 3'(QDEPTH);

    logic [31:0] r_pc;
    logic [1:0]  w_take_req;
    logic [1:0]  w_take;
    logic [1:0]  w_push;
    logic [2:0]  w_free;
    logic [2:0]  w_count;
    q_entry_t    w_wdata0;
    q_entry_t    w_wdata1;
    q_entry_t    w_rdata0;
    q_entry_t    w_rdata1;
    logic        w_unused;

    // Take is clamped to two and to what is queued; stall and redirect freeze both sides.
    always_comb begin
        w_take_req = (dec_take == 2'd3) ? 2'd2 : dec_take;
        w_take     = ({1'b0, w_take_req} > w_count) ? w_count[1:0] : w_take_req;
        w_free     = DEPTH3 - w_count + {1'b0, w_take};
        w_push     = (w_free >= 3'd2) ? 2'd2 : w_free[1:0];
        if (redirect_valid || stall) begin
            w_take = 2'd0;
            w_push = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else begin
            case (w_push)
                2'd2:    r_pc <= r_pc + 32'd8;
                2'd1:    r_pc <= r_pc + 32'd4;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign w_wdata0 = '{instr: imem_rd,  pc: r_pc};
    assign w_wdata1 = '{instr: imem_rd2, pc: r_pc + 32'd4};

    fetch_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (redirect_valid),
        .i_push   (w_push),
        .i_pop    (w_take),
        .i_wdata0 (w_wdata0),
        .i_wdata1 (w_wdata1),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1),
        .o_count  (w_count)
    );

    assign imem_a     = r_pc;
    assign q_count    = w_count;
    assign dec_valid  = {(w_count >= 3'd2), (w_count >= 3'd1)};
    assign dec_instr0 = w_rdata0.instr;
    assign dec_pc0    = w_rdata0.pc;
    assign dec_instr1 = w_rdata1.instr;
    assign dec_pc1    = w_rdata1.pc;
    assign w_unused   = ^redirect_pc[1:0];

endmodule
